// File: rtl/seq_alu_param.sv
// Multi-cycle signed ALU with parametrised operand width: single-cycle ADD/SUB/logic ops,
// radix-2 Booth multiply and non-restoring divide behind a BEGIN/END handshake.
module seq_alu_param #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     X,
  input  logic [WIDTH-1:0]     Y,
  input  logic [2:0]           op,
  input  logic                 BEGIN,
  output logic [2*WIDTH-1:0]   OUT,
  output logic                 END,
  output logic                 busy,
  output logic                 ovr,
  output logic                 dvz,
  output logic [CNT_W-1:0]     count
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_XOR = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EXEC    = 3'd1,
    MUL_IT  = 3'd2,
    DIV_IT  = 3'd3,
    DIV_FIX = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     x_q, x_d, y_q, y_d, q_q, q_d;
  logic [2:0]           op_q, op_d;
  // A carries two guard bits: Booth needs one for -M of the most-negative M, division needs two.
  logic [WIDTH+1:0]     a_q, a_d;
  logic                 qm1_q, qm1_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [2*WIDTH-1:0]   out_q, out_d;
  logic                 end_q, end_d, busy_q, busy_d, ovr_q, ovr_d, dvz_q, dvz_d;

  logic [WIDTH+1:0]     m_ext, dvs_ext, mul_sum, div_sh, div_new;
  logic [WIDTH-1:0]     r_add, r_sub, rem_mag, rem_s, quo_s;

  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v);
    abs_val = v[WIDTH-1] ? (~v + {{(WIDTH-1){1'b0}}, 1'b1}) : v;
  endfunction

  // Next-state, datapath and result computation.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    op_d    = op_q;
    a_d     = a_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    out_d   = out_q;
    ovr_d   = ovr_q;
    dvz_d   = dvz_q;
    r_add   = x_q + y_q;
    r_sub   = x_q - y_q;
    m_ext   = {{2{y_q[WIDTH-1]}}, y_q};
    dvs_ext = {2'b00, abs_val(y_q)};
    mul_sum = a_q;
    div_sh  = {a_q[WIDTH:0], q_q[WIDTH-1]};
    div_new = div_sh;
    rem_mag = a_q[WIDTH+1] ? (a_q[WIDTH-1:0] + dvs_ext[WIDTH-1:0]) : a_q[WIDTH-1:0];
    rem_s   = x_q[WIDTH-1] ? (ZERO_W - rem_mag) : rem_mag;
    quo_s   = (x_q[WIDTH-1] ^ y_q[WIDTH-1]) ? (ZERO_W - q_q) : q_q;

    case (state_q)
      IDLE: begin
        if (BEGIN) begin
          x_d     = X;
          y_d     = Y;
          op_d    = op;
          ovr_d   = 1'b0;
          dvz_d   = 1'b0;
          count_d = {CNT_W{1'b0}};
          a_d     = {(WIDTH+2){1'b0}};
          qm1_d   = 1'b0;
          case (op)
            OP_MUL: begin
              q_d     = X;
              state_d = MUL_IT;
            end
            OP_DIV: begin
              q_d     = abs_val(X);
              state_d = DIV_IT;
            end
            default: begin
              q_d     = ZERO_W;
              state_d = EXEC;
            end
          endcase
        end else begin
          count_d = {CNT_W{1'b0}};
        end
      end

      EXEC: begin
        state_d = DONE;
        ovr_d   = 1'b0;
        case (op_q)
          OP_ADD: begin
            out_d = {{WIDTH{r_add[WIDTH-1]}}, r_add};
            ovr_d = (x_q[WIDTH-1] == y_q[WIDTH-1]) && (r_add[WIDTH-1] != x_q[WIDTH-1]);
          end
          OP_SUB: begin
            out_d = {{WIDTH{r_sub[WIDTH-1]}}, r_sub};
            ovr_d = (x_q[WIDTH-1] != y_q[WIDTH-1]) && (r_sub[WIDTH-1] != x_q[WIDTH-1]);
          end
          OP_AND:  out_d = {ZERO_W, x_q & y_q};
          OP_OR:   out_d = {ZERO_W, x_q | y_q};
          OP_XOR:  out_d = {ZERO_W, x_q ^ y_q};
          OP_NOT:  out_d = {ZERO_W, ~x_q};
          default: out_d = {ZERO_W, ZERO_W};
        endcase
      end

      MUL_IT: begin
        case ({q_q[0], qm1_q})
          2'b01:   mul_sum = a_q + m_ext;
          2'b10:   mul_sum = a_q - m_ext;
          default: mul_sum = a_q;
        endcase
        a_d     = {mul_sum[WIDTH+1], mul_sum[WIDTH+1:1]};
        q_d     = {mul_sum[0], q_q[WIDTH-1:1]};
        qm1_d   = q_q[0];
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (count_q == CNT_LAST - {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = DONE;
          out_d   = {a_d[WIDTH-1:0], q_d};
          ovr_d   = 1'b0;
        end else begin
          state_d = MUL_IT;
        end
      end

      DIV_IT: begin
        div_new = a_q[WIDTH+1] ? (div_sh + dvs_ext) : (div_sh - dvs_ext);
        a_d     = div_new;
        q_d     = {q_q[WIDTH-2:0], ~div_new[WIDTH+1]};
        count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (count_q == CNT_LAST - {{(CNT_W-1){1'b0}}, 1'b1}) begin
          state_d = DIV_FIX;
        end else begin
          state_d = DIV_IT;
        end
      end

      DIV_FIX: begin
        state_d = DONE;
        if (y_q == ZERO_W) begin
          dvz_d = 1'b1;
          ovr_d = 1'b0;
          out_d = {x_q, ALL_ONES};
        end else if ((x_q == MOST_NEG) && (y_q == ALL_ONES)) begin
          dvz_d = 1'b0;
          ovr_d = 1'b1;
          out_d = {ZERO_W, MOST_NEG};
        end else begin
          dvz_d = 1'b0;
          ovr_d = 1'b0;
          out_d = {rem_s, quo_s};
        end
      end

      DONE: begin
        state_d = IDLE;
        count_d = {CNT_W{1'b0}};
      end

      default: begin
        state_d = IDLE;
        count_d = {CNT_W{1'b0}};
      end
    endcase

    end_d  = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= {WIDTH{1'b0}};
      y_q     <= {WIDTH{1'b0}};
      op_q    <= 3'b000;
      a_q     <= {(WIDTH+2){1'b0}};
      q_q     <= {WIDTH{1'b0}};
      qm1_q   <= 1'b0;
      count_q <= {CNT_W{1'b0}};
      out_q   <= {(2*WIDTH){1'b0}};
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      dvz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      op_q    <= op_d;
      a_q     <= a_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
      out_q   <= out_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      dvz_q   <= dvz_d;
    end
  end

  assign OUT   = out_q;
  assign END   = end_q;
  assign busy  = busy_q;
  assign ovr   = ovr_q;
  assign dvz   = dvz_q;
  assign count = count_q;

endmodule

// File: tb/tb_seq_alu_param.sv
// Directed self-checking bench for seq_alu_param at WIDTH=8 and WIDTH=16.
module tb_seq_alu_param;

  logic        clk;
  logic        reset;

  logic [7:0]  x8, y8;
  logic [2:0]  op8;
  logic        begin8;
  logic [15:0] out8;
  logic        end8, busy8, ovr8, dvz8;
  logic [3:0]  count8;

  logic [15:0] x16, y16;
  logic [2:0]  op16;
  logic        begin16;
  logic [31:0] out16;
  logic        end16, busy16, ovr16, dvz16;
  logic [4:0]  count16;

  int          total;
  int          bad;
  logic [15:0] prev_out8;

  seq_alu_param #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .X(x8), .Y(y8), .op(op8), .BEGIN(begin8),
    .OUT(out8), .END(end8), .busy(busy8), .ovr(ovr8), .dvz(dvz8), .count(count8)
  );

  seq_alu_param #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .X(x16), .Y(y16), .op(op16), .BEGIN(begin16),
    .OUT(out16), .END(end16), .busy(busy16), .ovr(ovr16), .dvz(dvz16), .count(count16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one 8-bit op, scramble the inputs after acceptance, and check latency and result.
  task automatic run8(input string tag, input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                      input int lat, input logic [15:0] eout, input logic eovr, input logic edvz);
    int seen;
    seen = 0;
    @(negedge clk);
    x8 = x; y8 = y; op8 = o; begin8 = 1'b1;
    @(posedge clk); #1;
    begin8 = 1'b0; x8 = ~x; y8 = ~y; op8 = ~o;
    chk({tag, "_busy0"}, {31'd0, busy8}, 32'd1);
    chk({tag, "_flagclr"}, {30'd0, ovr8, dvz8}, 32'd0);
    chk({tag, "_hold"}, {16'd0, out8}, {16'd0, prev_out8});
    for (int k = 1; k <= lat + 4; k++) begin
      @(posedge clk); #1;
      if (end8 && seen == 0) seen = k;
      if (seen != 0) break;
    end
    chk({tag, "_lat"}, seen, lat);
    chk({tag, "_out"}, {16'd0, out8}, {16'd0, eout});
    chk({tag, "_ovr"}, {31'd0, ovr8}, {31'd0, eovr});
    chk({tag, "_dvz"}, {31'd0, dvz8}, {31'd0, edvz});
    chk({tag, "_cnt"}, {28'd0, count8}, (o == 3'b100 || o == 3'b101) ? 32'd8 : 32'd0);
    @(posedge clk); #1;
    chk({tag, "_endfall"}, {30'd0, end8, busy8}, 32'd0);
    chk({tag, "_keep"}, {16'd0, out8}, {16'd0, eout});
    prev_out8 = eout;
  endtask

  initial begin
    logic [5:0] end_pat, busy_pat;
    int seen;
    total = 0; bad = 0; prev_out8 = 16'h0000;
    reset = 1'b1;
    x8 = 8'h00; y8 = 8'h00; op8 = 3'b000; begin8 = 1'b0;
    x16 = 16'h0000; y16 = 16'h0000; op16 = 3'b000; begin16 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", {16'd0, out8}, 32'd0);
    chk("rst_flags", {28'd0, end8, busy8, ovr8, dvz8}, 32'd0);
    chk("rst_cnt", {28'd0, count8}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    run8("mul_a", 3'b100, 8'hB9, 8'h85, 8, 16'h221D, 1'b0, 1'b0);
    run8("div_a", 3'b101, 8'hB9, 8'h85, 9, 16'hB900, 1'b0, 1'b0);
    run8("div_b", 3'b101, 8'd100, 8'hF9, 9, 16'h02F2, 1'b0, 1'b0);
    run8("add",   3'b000, 8'd100, 8'd50, 1, 16'hFF96, 1'b1, 1'b0);
    run8("sub",   3'b001, 8'h80, 8'h01, 1, 16'h007F, 1'b1, 1'b0);
    run8("xor",   3'b110, 8'hF0, 8'h3C, 1, 16'h00CC, 1'b0, 1'b0);
    run8("and",   3'b010, 8'hF0, 8'h3C, 1, 16'h0030, 1'b0, 1'b0);
    run8("or",    3'b011, 8'hF0, 8'h3C, 1, 16'h00FC, 1'b0, 1'b0);
    run8("not",   3'b111, 8'h5A, 8'h00, 1, 16'h00A5, 1'b0, 1'b0);
    run8("mul_mn", 3'b100, 8'h80, 8'h80, 8, 16'h4000, 1'b0, 1'b0);
    run8("mul_b", 3'b100, 8'd7, 8'hFD, 8, 16'hFFEB, 1'b0, 1'b0);
    run8("div_c", 3'b101, 8'hE9, 8'd5, 9, 16'hFDFC, 1'b0, 1'b0);
    run8("dvz",   3'b101, 8'h25, 8'h00, 9, 16'h25FF, 1'b0, 1'b1);
    run8("div_ov", 3'b101, 8'h80, 8'hFF, 9, 16'h0080, 1'b1, 1'b0);

    // Back-to-back: BEGIN held through DONE is taken on the first IDLE edge.
    end_pat = 6'd0; busy_pat = 6'd0;
    @(negedge clk);
    x8 = 8'h0F; y8 = 8'hFF; op8 = 3'b110; begin8 = 1'b1;
    @(posedge clk); #1;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk); #1;
      end_pat[k-1] = end8;
      busy_pat[k-1] = busy8;
      if (k == 3) begin8 = 1'b0;
    end
    chk("b2b_end", {26'd0, end_pat}, {26'd0, 6'b001001});
    chk("b2b_busy", {26'd0, busy_pat}, {26'd0, 6'b001101});
    chk("b2b_out", {16'd0, out8}, 32'h0000_00F0);
    prev_out8 = 16'h00F0;

    // 16-bit most-negative square with ignored BEGIN and late X change.
    seen = 0;
    @(negedge clk);
    x16 = 16'h8000; y16 = 16'h8000; op16 = 3'b100; begin16 = 1'b1;
    @(posedge clk); #1;
    begin16 = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      @(posedge clk); #1;
      if (k == 2) x16 = 16'h1234;
      if (k == 4) begin16 = 1'b1;
      if (k == 5) begin16 = 1'b0;
      if (end16 && seen == 0) seen = k;
      if (seen != 0) break;
    end
    chk("m16_lat", seen, 16);
    chk("m16_out", out16, 32'h4000_0000);
    chk("m16_ovr", {31'd0, ovr16}, 32'd0);
    chk("m16_cnt", {27'd0, count16}, 32'd16);
    repeat (2) @(posedge clk);
    #1;
    chk("m16_idle", {30'd0, end16, busy16}, 32'd0);

    // Reset in the middle of a DIV abandons it.
    @(negedge clk);
    x8 = 8'd77; y8 = 8'd5; op8 = 3'b101; begin8 = 1'b1;
    @(posedge clk); #1;
    begin8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rdiv_cnt4", {28'd0, count8}, 32'd4);
    reset = 1'b1;
    #1;
    chk("rdiv_out", {16'd0, out8}, 32'd0);
    chk("rdiv_flags", {28'd0, end8, busy8, ovr8, dvz8}, 32'd0);
    chk("rdiv_cnt", {28'd0, count8}, 32'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (k == 2) reset = 1'b0;
      if (end8) seen = 1;
    end
    chk("rdiv_noend", seen, 0);
    prev_out8 = 16'h0000;
    run8("add_r", 3'b000, 8'd3, 8'd4, 1, 16'h0007, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu_param.md
Name: seq_alu_param

Overview:
- Parametrised, multi-cycle signed ALU; next generation of the team's fixed 8-bit Booth/divide ALU.
- Operand width is set by WIDTH.
- Adds XOR/NOT ops, a busy indication, divide-by-zero detection and a defined signed-overflow policy for every op.
- Sits behind a BEGIN/END handshake driven by the datapath controller; the result is held stable until the next accepted BEGIN.

Parameters:
- WIDTH, 8, operand width in bits; legal values 4..32. OUT is 2*WIDTH.
- CNT_W, $clog2(WIDTH)+1, derived width of the iteration counter. Not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- X  in  WIDTH  signed operand A; multiplicand or dividend
- Y  in  WIDTH  signed operand B; multiplier or divisor
- op  in  3  operation select; sampled only on the accepting edge
- BEGIN  in  1  start request
- OUT  out  2*WIDTH  result
- END  out  1  one-cycle done pulse
- busy  out  1  high from the accepting edge until END falls
- ovr  out  1  signed overflow flag; valid with END and held afterwards
- dvz  out  1  divide-by-zero flag; valid with END and held afterwards
- count  out  CNT_W  iteration counter (debug visibility)

Behaviour:
- Reset (asynchronous, takes effect at any time, including mid-operation):
  - state=IDLE; OUT=0, END=0, busy=0, ovr=0, dvz=0, count=0.
  - All internal A/Q/M registers cleared.
  - Any operation in progress is abandoned with no END.
- Op encoding:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101 DIV, 110 XOR, 111 NOT X.
- States: IDLE, EXEC, MUL_IT, DIV_IT, DIV_FIX, DONE.
- Accept:
  - BEGIN=1 at a rising edge while in IDLE is the accepting edge, edge 0.
  - On that edge: latch X, Y, op; clear ovr/dvz; count=0; busy=1.
  - Next state is EXEC for ops 000-011, 110, 111; MUL_IT for MUL; DIV_IT for DIV.
  - BEGIN in any other state is ignored.
  - X, Y and op changes after edge 0 have no effect.
- Single-cycle ops:
  - EXEC computes the result at edge 1, then goes to DONE.
  - ADD/SUB: WIDTH-bit wrap result r; OUT = sign-extended r. ovr=1 when two's-complement overflow occurs.
  - Logic ops: OUT = zero-extended WIDTH-bit result; ovr=0.
- MUL (radix-2 Booth):
  - Registers: A (WIDTH bits), Q (WIDTH bits), q_-1, M=Y.
  - One iteration per edge, edges 1..WIDTH.
  - Each iteration: add/sub/no-op per {Q[0], q_-1}, then arithmetic right shift of {A,Q,q_-1}; count increments.
  - When count reaches WIDTH, go to DONE.
  - OUT={A,Q} is the full signed product. ovr=0 always.
  - Most-negative × most-negative must be exact, e.g. 0x80×0x80 = 0x4000 at WIDTH=8.
- DIV (non-restoring, on magnitudes):
  - Iterations on edges 1..WIDTH; DIV_FIX at edge WIDTH+1.
  - DIV_FIX does the remainder correction and sign fix, then goes to DONE.
  - Quotient truncates toward zero; the remainder takes the sign of the dividend.
  - OUT={remainder, quotient}: upper WIDTH bits remainder, lower WIDTH bits quotient.
- DIV special cases:
  - Y=0: dvz=1, quotient=all ones, remainder=X, ovr=0. Full iteration timing is still used.
  - X=most-negative and Y=-1: quotient=most-negative (wrapped), remainder=0, ovr=1.
- DONE:
  - END=1 and busy=1 for exactly one cycle, then IDLE with END=0 and busy=0.
- END timing, counting edges from the accepting edge 0:
  - END is high after edge 1 for single-cycle ops.
  - After edge WIDTH for MUL.
  - After edge WIDTH+1 for DIV.
- Result hold:
  - OUT, ovr and dvz update only when entering DONE.
  - They hold until the next DONE or reset. They are not cleared on accept; only ovr/dvz clear at accept.
- Back-to-back:
  - BEGIN held high through DONE is accepted on the first edge in IDLE.
  - Minimum issue interval is therefore latency+2 edges.
- count:
  - 0 in IDLE/EXEC.
  - Equals the number of completed iterations in MUL_IT/DIV_IT.
  - Holds its value through DIV_FIX/DONE.

Test Plan:
- WIDTH=8, MUL, X=0xB9 (-71), Y=0x85 (-123) -> END after edge 8; OUT=0x221D (8733); ovr=0; busy low the cycle after END.
- WIDTH=8, DIV, X=-71, Y=-123 -> END after edge 9; OUT={0xB9, 0x00} (remainder -71, quotient 0). Then X=100, Y=-7 -> quotient=0xF2 (-14), remainder=0x02.
- WIDTH=8:
  - ADD 100+50 -> OUT=0xFF96, ovr=1.
  - SUB -128-1 -> OUT=0x007F, ovr=1.
  - XOR 0xF0^0x3C -> OUT=0x00CC, ovr=0.
  - All three: END after edge 1.
- WIDTH=8, DIV by Y=0 with X=0x25 -> dvz=1; OUT={0x25, 0xFF}. DIV -128/-1 -> OUT={0x00, 0x80}, ovr=1.
- WIDTH=16, MUL 0x8000×0x8000 -> OUT=0x40000000 after edge 16. BEGIN pulsed at edge 5 is ignored. X changed at edge 3 has no effect.
- Assert reset at edge 4 of an 8-bit DIV -> all outputs 0 immediately, no END. Release reset and issue ADD 3+4 -> OUT=0x0007, END after edge 1.
